prbs_stream_checker: RTL and testbench



---
 rtl/prbs_stream_checker.sv | 152 +++++++++++++++
 tb/tb_prbs_stream_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs_stream_checker.sv
// Receive-side PRBS checker: self-synchronising hunt, then a free-running reference LFSR
// while locked, with per-beat and accumulated (saturating) bit-error statistics.
module prbs_stream_checker #(
  parameter int unsigned    W          = 8,
  parameter int unsigned    N          = 7,
  parameter logic [N-1:0]   TAPS       = 7'h60,
  parameter int unsigned    LOCK_COUNT = 4,
  parameter int unsigned    LOSS_COUNT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  input  logic                       clr_count,
  output logic                       locked,
  output logic                       err_valid,
  output logic [$clog2(W+1)-1:0]     err_bits,
  output logic [31:0]                err_count
);

  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [0:0] StHunt   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [7:0] LockCnt = 8'(LOCK_COUNT);
  localparam logic [7:0] LossCnt = 8'(LOSS_COUNT);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [7:0]    good_q, good_d;
  logic [7:0]    bad_q, bad_d;
  logic          err_valid_q, err_valid_d;
  logic [CW-1:0] err_bits_q, err_bits_d;
  logic [31:0]   err_count_q, err_count_d;

  logic [W-1:0]  pred_h, pred_l;
  logic [N-1:0]  hist_h, hist_l;
  logic [CW-1:0] nerr_h, nerr_l;
  logic [32:0]   count_sum;

  // History is kept in time order: hist_q[N-1] is the most recent bit. The bit stream of a
  // beat is therefore {word, history}, and "k+1 positions earlier" is a fixed index offset.
  always_comb begin : p_predict
    logic [N+W-1:0] seq_h;
    logic [N+W-1:0] seq_l;
    seq_h  = {in_data, hist_q};
    seq_l  = {{W{1'b0}}, hist_q};
    pred_h = '0;
    pred_l = '0;
    for (int i = 0; i < int'(W); i++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (TAPS[k]) begin
          pred_h[i] = pred_h[i] ^ seq_h[N+i-k-1];
          pred_l[i] = pred_l[i] ^ seq_l[N+i-k-1];
        end
      end
      // Locked reference feeds back its own predictions, so one line error counts once.
      seq_l[N+i] = pred_l[i];
    end
    hist_h = seq_h[N+W-1:W];
    hist_l = seq_l[N+W-1:W];
  end

  always_comb begin : p_popcount
    logic [W-1:0] mm_h;
    logic [W-1:0] mm_l;
    mm_h   = in_data ^ pred_h;
    mm_l   = in_data ^ pred_l;
    nerr_h = '0;
    nerr_l = '0;
    for (int i = 0; i < int'(W); i++) begin
      nerr_h = nerr_h + CW'(mm_h[i]);
      nerr_l = nerr_l + CW'(mm_l[i]);
    end
  end

  assign count_sum = {1'b0, err_count_q} + 33'(nerr_l);

  always_comb begin : p_next
    state_d     = state_q;
    hist_d      = hist_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_valid_d = 1'b0;
    err_bits_d  = err_bits_q;
    err_count_d = err_count_q;

    if (in_valid) begin
      if (state_q == StHunt) begin
        hist_d = hist_h;
        // An all-zero history is the LFSR lock-up state and never qualifies.
        if ((hist_h == '0) || (nerr_h != '0)) begin
          good_d = '0;
        end else if (good_q + 8'd1 == LockCnt) begin
          state_d = StLocked;
          good_d  = '0;
          bad_d   = '0;
        end else begin
          good_d = good_q + 8'd1;
        end
      end else begin
        hist_d      = hist_l;
        err_valid_d = 1'b1;
        err_bits_d  = nerr_l;
        err_count_d = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
        if (nerr_l != '0) begin
          if (bad_q + 8'd1 == LossCnt) begin
            state_d = StHunt;
            good_d  = '0;
            bad_d   = '0;
            hist_d  = hist_h;
          end else begin
            bad_d = bad_q + 8'd1;
          end
        end else begin
          bad_d = '0;
        end
      end
    end

    if (clr_count) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      hist_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_valid_q <= 1'b0;
      err_bits_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_valid_q <= err_valid_d;
      err_bits_q  <= err_bits_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_valid = err_valid_q;
  assign err_bits  = err_bits_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Table-driven bench for prbs_stream_checker: a stimulus table of beats with hand-derived
// expected outputs, pushed to a scoreboard when driven and compared one cycle later.
module tb_prbs_stream_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_count;
  logic        locked;
  logic        err_valid;
  logic [3:0]  err_bits;
  logic [31:0] err_count;

  int unsigned checks;
  int unsigned errors;

  prbs_stream_checker #(
    .W          (8),
    .N          (7),
    .TAPS       (7'h60),
    .LOCK_COUNT (4),
    .LOSS_COUNT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_count (clr_count),
    .locked    (locked),
    .err_valid (err_valid),
    .err_bits  (err_bits),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        zero;
    logic [7:0]  mask;
    logic        clr;
    logic        el;
    logic        ev;
    int unsigned eb;
    int unsigned ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  // Generator state: gen_s[j] is the bit j+1 positions back; b[n] = b[n-6] ^ b[n-7].
  logic [6:0] gen_s;

  task automatic gen_word(output logic [7:0] w);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b     = gen_s[5] ^ gen_s[6];
      w[i]  = b;
      gen_s = {gen_s[5:0], b};
    end
  endtask

  task automatic add(input logic r, input logic v, input logic z, input logic [7:0] m,
                     input logic c, input logic el, input logic ev, input int unsigned eb,
                     input int unsigned ec);
    vec_t t;
    t.rst = r; t.valid = v; t.zero = z; t.mask = m; t.clr = c;
    t.el = el; t.ev = ev; t.eb = eb; t.ec = ec;
    tbl.push_back(t);
  endtask

  // Beat of the reference stream, optionally corrupted by mask.
  task automatic beat(input logic [7:0] m, input logic c, input logic el, input logic ev,
                      input int unsigned eb, input int unsigned ec);
    add(1'b0, 1'b1, 1'b0, m, c, el, ev, eb, ec);
  endtask

  task automatic idle(input logic c, input logic el, input int unsigned ec);
    add(1'b0, 1'b0, 1'b0, 8'h00, c, el, 1'b0, 0, ec);
  endtask

  task automatic check(input int idx, input vec_t e);
    checks++;
    if (locked !== e.el) begin
      errors++;
      $display("FAIL step %0d locked: got %b want %b", idx, locked, e.el);
    end
    checks++;
    if (err_valid !== e.ev) begin
      errors++;
      $display("FAIL step %0d err_valid: got %b want %b", idx, err_valid, e.ev);
    end
    if (e.ev || e.rst) begin
      checks++;
      if (err_bits !== 4'(e.eb)) begin
        errors++;
        $display("FAIL step %0d err_bits: got %0d want %0d", idx, err_bits, e.eb);
      end
    end
    checks++;
    if (err_count !== 32'(e.ec)) begin
      errors++;
      $display("FAIL step %0d err_count: got %0d want %0d", idx, err_count, e.ec);
    end
  endtask

  logic [7:0] w;
  vec_t       e;
  int         step;

  initial begin
    checks    = 0;
    errors    = 0;
    gen_s     = 7'h01;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    clr_count = 1'b0;

    // Reset state.
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    // Clean lock: beat 0 mismatches against the zero history, beats 1..4 qualify.
    for (int b = 0; b < 4; b++) beat(8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int b = 5; b < 10; b++) beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 0);
    // Single error while locked does not multiply.
    beat(8'h08, 1'b0, 1'b1, 1'b1, 1, 1);
    for (int b = 11; b < 20; b++) beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 1);
    // Four errored beats drop lock; that last beat is still counted.
    for (int b = 20; b < 23; b++) beat(8'h01, 1'b0, 1'b1, 1'b1, 1, 2 + (b - 20));
    beat(8'h01, 1'b0, 1'b0, 1'b1, 1, 5);
    for (int b = 24; b < 27; b++) beat(8'h00, 1'b0, 1'b0, 1'b0, 0, 5);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 0, 5);
    beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 5);
    // clr_count collides with a 2-bit error, then a 1-bit error counts again.
    beat(8'h11, 1'b1, 1'b1, 1'b1, 2, 0);
    beat(8'h04, 1'b0, 1'b1, 1'b1, 1, 1);
    beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 1);
    for (int j = 0; j < 4; j++) begin
      logic [7:0] mk;
      mk = (j == 0) ? 8'h02 : (j == 1) ? 8'h40 : (j == 2) ? 8'h80 : 8'h01;
      beat(mk, 1'b0, 1'b1, 1'b1, 1, 2 + j);
      beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 2 + j);
    end
    // Reset while locked with err_count=5; the in-flight beat is discarded.
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    // Complemented beat always breaks the two-tap parity; the next beat still sees the
    // complemented history, so four further clean beats are needed to relock.
    beat(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int b = 0; b < 4; b++) beat(8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 0, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 0);
    beat(8'h01, 1'b0, 1'b1, 1'b1, 1, 1);
    idle(1'b1, 1'b1, 0);
    idle(1'b0, 1'b1, 0);
    // Zero stream never qualifies.
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int b = 0; b < 50; b++) add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    // Gapped stream: lock after four clean valid beats, no err_valid in gaps.
    beat(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(1'b0, 1'b0, 0);
    beat(8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int g = 0; g < 3; g++) begin
      idle(1'b0, 1'b0, 0);
      beat(8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    idle(1'b0, 1'b0, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(1'b0, 1'b1, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 0);
    beat(8'h00, 1'b0, 1'b1, 1'b1, 0, 0);

    step = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(step, e);
        step++;
      end
      rst       = tbl[i].rst;
      in_valid  = tbl[i].valid;
      clr_count = tbl[i].clr;
      if (!tbl[i].valid) begin
        in_data = 8'($urandom_range(0, 255));
      end else if (tbl[i].zero) begin
        in_data = 8'h00;
      end else begin
        gen_word(w);
        in_data = w ^ tbl[i].mask;
      end
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(step, e);
      step++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
